// File: rtl/alu_shift_issue_if.sv
// alu_shift_issue_if: dispatch-side input channel and shift-unit output channel of alu_shift_issue
interface alu_shift_issue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_ADDR_W  = 5
);
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [31:0]           instr_i;
  logic [DATA_WIDTH-1:0] rs1_data_i;
  logic [DATA_WIDTH-1:0] rs2_data_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DATA_WIDTH-1:0] rs1_data_o;
  logic [4:0]            shamt_o;
  logic                  shift_l_o;
  logic                  arith_o;
  logic [RD_ADDR_W-1:0]  rd_addr_o;
  logic                  illegal_o;
  modport slave (
    input  in_valid_i, instr_i, rs1_data_i, rs2_data_i, out_ready_i,
    output in_ready_o, out_valid_o, rs1_data_o, shamt_o, shift_l_o, arith_o, rd_addr_o, illegal_o
  );
  modport master (
    output in_valid_i, instr_i, rs1_data_i, rs2_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, rs1_data_o, shamt_o, shift_l_o, arith_o, rd_addr_o, illegal_o
  );
endinterface

// File: rtl/alu_shift_issue.sv
// alu_shift_issue: decodes RV32I shift ops and issues them through a 2-entry skid FIFO; ALU_SHIFT_ISSUE_STATS_EN adds issue/illegal counters
module alu_shift_issue #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_ADDR_W  = 5,
  parameter int FIFO_DEPTH = 2
) (
  input logic              clk,
  input logic              arst_ni,
  alu_shift_issue_if.slave bus
`ifdef ALU_SHIFT_ISSUE_STATS_EN
  ,
  input  logic             stat_clr_i,
  output logic [31:0]      stat_issued_o,
  output logic [15:0]      stat_illegal_o
`endif
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] rs1;
    logic [4:0]            shamt;
    logic                  shift_l;
    logic                  arith;
    logic [RD_ADDR_W-1:0]  rd;
  } entry_t;
  entry_t     mem_q [FIFO_DEPTH];
  entry_t     entry_d;
  entry_t     head;
  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, rd_ptr_q, illegal_q;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       is_r, is_i, legal, in_fire, out_fire, push;
  logic       unused_bits;
  assign unused_bits = ^{bus.rs2_data_i[DATA_WIDTH-1:5], bus.instr_i[19:15]};
  // decode the incoming word into a FIFO entry and classify it as a legal shift
  always_comb begin
    opcode          = bus.instr_i[6:0];
    funct3          = bus.instr_i[14:12];
    funct7          = bus.instr_i[31:25];
    is_r            = opcode == 7'b0110011;
    is_i            = opcode == 7'b0010011;
    legal           = (is_r | is_i) &
                      ((funct3 == 3'b001 & funct7 == 7'b0000000) |
                       (funct3 == 3'b101 & (funct7 == 7'b0000000 | funct7 == 7'b0100000)));
    entry_d.rs1     = bus.rs1_data_i;
    entry_d.shamt   = is_r ? bus.rs2_data_i[4:0] : bus.instr_i[24:20];
    entry_d.shift_l = funct3 == 3'b001;
    entry_d.arith   = funct7[5];
    entry_d.rd      = bus.instr_i[11:7];
  end
  // handshake qualification and occupancy update; illegal fires never occupy a slot
  always_comb begin
    in_fire  = bus.in_valid_i & bus.in_ready_o;
    out_fire = bus.out_valid_o & bus.out_ready_i;
    push     = in_fire & legal;
    count_d  = count_q + {1'b0, push} - {1'b0, out_fire};
  end
  assign head            = mem_q[rd_ptr_q];
  assign bus.in_ready_o  = count_q != 2'd2;
  assign bus.out_valid_o = count_q != 2'd0;
  assign bus.rs1_data_o  = head.rs1;
  assign bus.shamt_o     = head.shamt;
  assign bus.shift_l_o   = head.shift_l;
  assign bus.arith_o     = head.arith;
  assign bus.rd_addr_o   = head.rd;
  assign bus.illegal_o   = illegal_q;
  // FIFO storage, 1-bit wrapping pointers, occupancy and the registered illegal pulse
  always_ff @(posedge clk or negedge arst_ni) begin
    if (!arst_ni) begin
      count_q   <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      illegal_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q   <= count_d;
      illegal_q <= in_fire & ~legal;
      if (push) begin
        mem_q[wr_ptr_q] <= entry_d;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (out_fire) rd_ptr_q <= ~rd_ptr_q;
    end
  end
`ifdef ALU_SHIFT_ISSUE_STATS_EN
  logic [31:0] issued_q;
  logic [15:0] illegal_cnt_q;
  // wrapping event counters; clear wins over increment
  always_ff @(posedge clk or negedge arst_ni) begin
    if (!arst_ni) begin
      issued_q      <= '0;
      illegal_cnt_q <= '0;
    end else if (stat_clr_i) begin
      issued_q      <= '0;
      illegal_cnt_q <= '0;
    end else begin
      issued_q      <= issued_q + 32'(out_fire);
      illegal_cnt_q <= illegal_cnt_q + 16'(in_fire & ~legal);
    end
  end
  assign stat_issued_o  = issued_q;
  assign stat_illegal_o = illegal_cnt_q;
`endif
endmodule
